// File: rtl/hex_disp_pkg.sv
// Package: hex_disp_pkg
// Shared constants and types for the hex display controller.
//   SEG_0..SEG_F : active-low 7-segment patterns, bit6=a .. bit0=g
//   SEG_BLANK    : all segments off
//   SEG_LUT      : nibble-indexed view of the patterns
//   state_t      : display state {EMPTY, SHOWING}
//   clog2()      : counter width helper (returns at least 1)
package hex_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0001100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Element [n] is the pattern for nibble n.
  localparam logic [15:0][6:0] SEG_LUT = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  typedef enum logic {EMPTY = 1'b0, SHOWING = 1'b1} state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/hex_digit_enc.sv
// Module: hex_digit_enc
// Combinational nibble -> active-low 7-segment pattern.
//   nib : hex digit 0..F
//   seg : bit6=a .. bit0=g, active low
module hex_digit_enc
  import hex_disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[nib];

endmodule

// File: rtl/hex_display_ctrl.sv
// Module: hex_display_ctrl
// Registered N-digit hex display controller for active-low 7-segment displays.
// Latches a packed hex value on load and decodes every nibble, with leading-zero
// blanking, per-digit forced blanking and per-digit blinking.
//   clk, reset  : single clock, synchronous active-high reset
//   load, value : capture packed nibbles (digit i = value[4i+:4], digit 0 = LSD)
//   lz_blank    : blank leading zeros (digit 0 always shown)
//   blank_mask  : per-digit forced blank
//   blink_mask  : per-digit blink enable
//   seg_out     : digit i = seg_out[7i+:7], active low, registered
//   shown       : a value has been loaded since reset
// Optional macro HEX_SCAN_EN adds a multiplexed scan output:
//   scan_seg    : pattern for the currently selected digit (registered)
//   scan_sel    : active-low one-hot digit select
module hex_display_ctrl
  import hex_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25_000_000,
  parameter int SCAN_DIV   = 50_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    lz_blank,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7*NUM_DIGITS-1:0] seg_out,
  output logic                    shown
`ifdef HEX_SCAN_EN
  ,
  output logic [6:0]              scan_seg,
  output logic [NUM_DIGITS-1:0]   scan_sel
`endif
);

  localparam int BW = clog2(BLINK_DIV);

  state_t                          state_q, state_d;
  logic [NUM_DIGITS-1:0][3:0]      value_q;
  logic [BW-1:0]                   blink_cnt;
  logic                            blink_ph;
  logic [NUM_DIGITS:1]             hi_zero;   // digit i and every digit above it are 0
  logic [NUM_DIGITS-1:0]           lzb;
  logic [NUM_DIGITS-1:0][6:0]      dec, seg_d, seg_q;

  // FSM: EMPTY until the first load, then SHOWING until reset.
  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (load) state_d = SHOWING;
      SHOWING: state_d = SHOWING;
      default: state_d = EMPTY;
    endcase
  end

  assign shown = (state_q == SHOWING);

  always_ff @(posedge clk) begin
    if (reset)     value_q <= '0;
    else if (load) value_q <= value;
  end

  // Free-running blink timebase, independent of load.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink_ph  <= ~blink_ph;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign hi_zero[NUM_DIGITS] = 1'b1;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    hex_digit_enc u_enc (.nib(value_q[i]), .seg(dec[i]));

    if (i == 0) begin : g_lsd
      assign lzb[i] = 1'b0;
    end else begin : g_msd
      assign hi_zero[i] = (value_q[i] == 4'h0) && hi_zero[i+1];
      assign lzb[i]     = lz_blank && hi_zero[i];
    end

    // Priority: EMPTY > blank_mask > LZ blank > blink-off > decoded nibble.
    assign seg_d[i] = ((state_q == EMPTY) || blank_mask[i] || lzb[i] ||
                       (blink_ph && blink_mask[i])) ? SEG_BLANK : dec[i];
  end

  always_ff @(posedge clk) begin
    if (reset) seg_q <= {NUM_DIGITS{SEG_BLANK}};
    else       seg_q <= seg_d;
  end

  assign seg_out = seg_q;

`ifdef HEX_SCAN_EN
  localparam int SW = clog2(SCAN_DIV);
  localparam int IW = clog2(NUM_DIGITS);

  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] scan_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Select and segments both sample scan_idx on the same edge, so they stay aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_seg <= SEG_BLANK;
      scan_sel <= ~NUM_DIGITS'(1);
    end else begin
      scan_seg <= seg_q[scan_idx];
      scan_sel <= ~(NUM_DIGITS'(1) << scan_idx);
    end
  end
`endif

endmodule

// File: tb/tb_hex_display_ctrl.sv
module tb_hex_display_ctrl;

  localparam int ND = 4;

  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010, S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100, S5 = 7'b0100100, S6 = 7'b0100000, S7 = 7'b0001111;
  localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0001100, SA = 7'b0001000, Sb = 7'b1100000;
  localparam logic [6:0] SC = 7'b0110001, Sd = 7'b1000010, SE = 7'b0110000, SF = 7'b0111000;
  localparam logic [6:0] SB = 7'b1111111;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load = 1'b0;
  logic [15:0]   value = '0;
  logic          lz_blank = 1'b0;
  logic [ND-1:0] blank_mask = '0;
  logic [ND-1:0] blink_mask = '0;
  logic [27:0]   seg_out;
  logic          shown;
`ifdef HEX_SCAN_EN
  logic [6:0]    scan_seg;
  logic [ND-1:0] scan_sel;
`endif

  hex_display_ctrl #(.NUM_DIGITS(ND), .BLINK_DIV(4), .SCAN_DIV(3)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .lz_blank(lz_blank),
    .blank_mask(blank_mask), .blink_mask(blink_mask), .seg_out(seg_out), .shown(shown)
`ifdef HEX_SCAN_EN
    , .scan_seg(scan_seg), .scan_sel(scan_sel)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]   val;
    logic          lz;
    logic [ND-1:0] bmask;
    logic [27:0]   exp_seg;
  } vec_t;

  vec_t        vecs[10];
  logic [6:0]  dec_t[16];
  int          nvec = 0;
  int          nfail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [27:0] act, input logic [27:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Digit 0 pattern after edge m (m counted from the last reset edge), value 1234, blink on digit 0.
  function automatic logic [6:0] exp_d0(input int m);
    return ((((m - 1) / 4) % 2) != 0) ? SB : S4;
  endfunction

  initial begin
    dec_t = '{S0, S1, S2, S3, S4, S5, S6, S7, S8, S9, SA, Sb, SC, Sd, SE, SF};

    vecs[0] = '{16'h0B2D, 1'b1, 4'b0000, {SB, Sb, S2, Sd}};
    vecs[1] = '{16'h0B2D, 1'b0, 4'b0000, {S0, Sb, S2, Sd}};
    vecs[2] = '{16'h0000, 1'b1, 4'b0000, {SB, SB, SB, S0}};
    vecs[3] = '{16'h0000, 1'b0, 4'b0000, {S0, S0, S0, S0}};
    vecs[4] = '{16'h00F0, 1'b1, 4'b0000, {SB, SB, SF, S0}};
    vecs[5] = '{16'h8000, 1'b1, 4'b0000, {S8, S0, S0, S0}};
    vecs[6] = '{16'h1234, 1'b1, 4'b0001, {S1, S2, S3, SB}};
    vecs[7] = '{16'h0001, 1'b1, 4'b1000, {SB, SB, SB, S1}};
    vecs[8] = '{16'hABCD, 1'b0, 4'b0110, {SA, SB, SB, Sd}};
    vecs[9] = '{16'h0007, 1'b1, 4'b0001, {SB, SB, SB, SB}};

    // Reset state
    tick();
    tick();
    chk("reset_seg", seg_out, 28'hFFFFFFF);
    chk("reset_shown", {27'b0, shown}, 28'd0);
`ifdef HEX_SCAN_EN
    chk("reset_scan_sel", {24'b0, scan_sel}, 28'b1110);
    chk("reset_scan_seg", {21'b0, scan_seg}, {21'b0, SB});
`endif

    // First load of 0: shown on the load edge, segments one edge later
    reset = 1'b0;
    load  = 1'b1;
    value = 16'h0000;
    tick();
    load = 1'b0;
    chk("load_edge_shown", {27'b0, shown}, 28'd1);
    chk("load_edge_seg_blank", seg_out, 28'hFFFFFFF);
    tick();
    chk("first_zero", seg_out, {S0, S0, S0, S0});

    // Table vectors
    for (int i = 0; i < 10; i++) begin
      value      = vecs[i].val;
      lz_blank   = vecs[i].lz;
      blank_mask = vecs[i].bmask;
      load       = 1'b1;
      tick();
      load = 1'b0;
      tick();
      chk($sformatf("vec%0d", i), seg_out, vecs[i].exp_seg);
      chk($sformatf("vec%0d_shown", i), {27'b0, shown}, 28'd1);
    end

    // Nibble sweep on digit 0
    lz_blank   = 1'b1;
    blank_mask = '0;
    for (int n = 0; n < 16; n++) begin
      value = 16'(n);
      load  = 1'b1;
      tick();
      load = 1'b0;
      tick();
      chk($sformatf("sweep%0d", n), seg_out, {SB, SB, SB, dec_t[n]});
      if (n == 11 && seg_out[6:0] === S8) begin
        nfail++;
        $display("FAIL sweep_b_vs_8: got %b which is the 8 pattern", seg_out[6:0]);
      end
      if (n == 13 && seg_out[6:0] === S0) begin
        nfail++;
        $display("FAIL sweep_d_vs_0: got %b which is the 0 pattern", seg_out[6:0]);
      end
      if (n == 11 || n == 13) nvec++;
    end

    // Back-to-back loads: last value wins
    lz_blank = 1'b0;
    value = 16'h1111; load = 1'b1; tick();
    value = 16'h2222; tick();
    load = 1'b0; tick();
    chk("b2b_last_wins", seg_out, {S2, S2, S2, S2});

    // Blink (and scan) timeline from a fresh reset edge e0
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    load       = 1'b1;
    value      = 16'h1234;
    blink_mask = 4'b0001;
    tick();
    load = 1'b0;
    for (int n = 2; n <= 17; n++) begin
      tick();
      chk($sformatf("blink_e%0d", n), seg_out, {S1, S2, S3, exp_d0(n)});
`ifdef HEX_SCAN_EN
      if (n >= 3) begin
        int k;
        logic [6:0] es;
        k = ((n - 1) / 3) % 4;
        case (k)
          0:       es = exp_d0(n - 1);
          1:       es = S3;
          2:       es = S2;
          default: es = S1;
        endcase
        chk($sformatf("scan_sel_e%0d", n), {24'b0, scan_sel}, {24'b0, ~(4'b0001 << k)});
        chk($sformatf("scan_seg_e%0d", n), {21'b0, scan_seg}, {21'b0, es});
      end
`endif
    end

    // Forced blank overrides blink on, one cycle after the mask changes
    blank_mask = 4'b0001;
    tick();
    chk("blank_over_blink0", seg_out, {S1, S2, S3, SB});
    tick();
    tick();
    tick();
    chk("blank_over_blink1", seg_out, {S1, S2, S3, SB});

    // Mask release reaches the output after one edge
    blank_mask = '0;
    blink_mask = '0;
    tick();
    chk("mask_release", seg_out, {S1, S2, S3, S4});

    // Reset with a load in the same cycle: reset wins, load ignored
    reset = 1'b1;
    load  = 1'b1;
    value = 16'hFFFF;
    tick();
    chk("reset_mid_seg", seg_out, 28'hFFFFFFF);
    chk("reset_mid_shown", {27'b0, shown}, 28'd0);
    reset = 1'b0;
    load  = 1'b0;
    tick();
    tick();
    chk("reset_mid_load_ignored_seg", seg_out, 28'hFFFFFFF);
    chk("reset_mid_load_ignored_shown", {27'b0, shown}, 28'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
